// File: rtl/alu_muldiv_sequencer_if.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module : alu_muldiv_sequencer_if
// Brief  : Request/result handshake and shared-ALU bus for the mul/div sequencer
// Rev    : 1.0
// ============================================================================
interface alu_muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       func;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_out;

  // slave is the sequencer; master is the pipeline/ALU side
  modport slave (
    input  start, func, src_a, src_b, alu_out,
    output busy, done, stall, result, alu_op, alu_a, alu_b
  );

  modport master (
    output start, func, src_a, src_b, alu_out,
    input  busy, done, stall, result, alu_op, alu_a, alu_b
  );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module : alu_muldiv_sequencer
// Brief  : MUL/DIVU/REMU by iterating the shared ALU once per cycle.
//          Divide support enabled by defining MULSEQ_DIV_EN.
// Rev    : 1.0
// ============================================================================
module alu_muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  wire logic             clk,
  input  wire logic             rst,
  alu_muldiv_sequencer_if.slave bus
);

  localparam logic [2:0]      C_OP_ADD = 3'b000;
  localparam logic [2:0]      C_OP_SUB = 3'b001;
  localparam logic [CNTW-1:0] C_LAST   = CNTW'(WIDTH - 1);
  localparam logic [CNTW-1:0] C_ONE    = CNTW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNTW-1:0]  r_cnt;
  logic             r_is_div;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  // r_acc: product accumulator / partial remainder
  // r_x  : multiplicand / divisor;  r_y: multiplier / quotient shift register
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;

  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_x_nxt;
  logic [WIDTH-1:0] w_y_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic [2:0]       w_alu_op;
  logic [WIDTH-1:0] w_alu_a;
  logic [WIDTH-1:0] w_alu_b;
  logic             w_accept;
  logic             w_last;

`ifdef MULSEQ_DIV_EN
  logic             r_rem_sel;
  logic [WIDTH:0]   w_shift;
  logic             w_take;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (r_cnt == C_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ALU drive and per-iteration datapath; idle/done leave the ALU at add 0+0
  always_comb begin
    w_alu_op  = C_OP_ADD;
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_acc_nxt = r_acc;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_res_nxt = '0;
`ifdef MULSEQ_DIV_EN
    w_shift   = {r_acc, r_y[WIDTH-1]};
    w_take    = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_x);
`endif
    if (r_state == S_RUN) begin
      if (!r_is_div) begin
        w_alu_a   = r_acc;
        w_alu_b   = r_y[0] ? r_x : '0;
        w_acc_nxt = bus.alu_out;
        w_x_nxt   = r_x << 1;
        w_y_nxt   = r_y >> 1;
      end
`ifdef MULSEQ_DIV_EN
      else begin
        w_alu_op = C_OP_SUB;
        w_alu_a  = w_shift[WIDTH-1:0];
        w_alu_b  = r_x;
        if (w_take) begin
          w_acc_nxt = bus.alu_out;
          w_y_nxt   = {r_y[WIDTH-2:0], 1'b1};
        end else begin
          w_acc_nxt = w_shift[WIDTH-1:0];
          w_y_nxt   = {r_y[WIDTH-2:0], 1'b0};
        end
      end
`endif
    end
    // without the divider a 1x request simply returns zero
    if (!r_is_div) begin
      w_res_nxt = w_acc_nxt;
    end
`ifdef MULSEQ_DIV_EN
    else if (r_rem_sel) begin
      w_res_nxt = w_acc_nxt;
    end else begin
      w_res_nxt = w_y_nxt;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_acc     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
`ifdef MULSEQ_DIV_EN
      r_rem_sel <= 1'b0;
`endif
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      if (w_accept) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_is_div <= bus.func[1];
`ifdef MULSEQ_DIV_EN
        r_rem_sel <= bus.func[0];
        if (bus.func[1]) begin
          r_x <= bus.src_b;
          r_y <= bus.src_a;
        end else begin
          r_x <= bus.src_a;
          r_y <= bus.src_b;
        end
`else
        r_x <= bus.src_a;
        r_y <= bus.src_b;
`endif
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + C_ONE;
        r_acc <= w_acc_nxt;
        r_x   <= w_x_nxt;
        r_y   <= w_y_nxt;
        if (w_last) begin
          r_result <= w_res_nxt;
        end
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.stall  = bus.start | r_busy;
  assign bus.alu_op = w_alu_op;
  assign bus.alu_a  = w_alu_a;
  assign bus.alu_b  = w_alu_b;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_sequencer.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module : tb_alu_muldiv_sequencer
// Brief  : Scoreboard bench for the mul/div sequencer with a behavioural ALU.
//          Expectations follow MULSEQ_DIV_EN when it is defined.
// Rev    : 1.0
// ============================================================================
module tb_alu_muldiv_sequencer;

  localparam int WIDTH = 32;
  localparam int CNTW  = 6;
`ifdef MULSEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [WIDTH-1:0] sb_q[$];

  alu_muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_muldiv_sequencer #(
    .WIDTH(WIDTH),
    .CNTW (CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.alu_op)
      3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = '0;
    endcase
  end

  function automatic logic [WIDTH-1:0] model(input logic [1:0] f,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = a * b;
    case (f)
      2'b00, 2'b01: return p[WIDTH-1:0];
      2'b10:        return !DIV_EN ? '0 : (b == 0 ? '1 : a / b);
      default:      return !DIV_EN ? '0 : (b == 0 ? a : a % b);
    endcase
  endfunction

  task automatic send_op(input logic [1:0] f, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    int g = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    bus.func  = f;
    bus.src_a = a;
    bus.src_b = b;
    bus.start = 1'b1;
    sb_q.push_back(exp);
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // lat = edges after the accept edge until done is seen
  task automatic wait_done(output int lat, output bit to, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end while (bus.done !== 1'b1 && lat < 100);
    to = (bus.done !== 1'b1);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.func  = 2'b00;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", bus.result); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", bus.stall); end
    checks++; if (bus.alu_op !== 3'b000 || bus.alu_a !== '0 || bus.alu_b !== '0) begin
      errors++; $display("FAIL reset_alu op=%b a=%h b=%h want all 0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul_latency();
    int lat; bit to; bit bok; logic [WIDTH-1:0] exp;
    send_op(2'b00, 32'd7, 32'd6, 32'd42);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mul_stall_on_start got=%b want=1", bus.stall); end
    accept();
    wait_done(lat, to, bok);
    exp = sb_q.pop_front();
    checks++; if (to || lat != WIDTH) begin errors++; $display("FAIL mul_latency got=%0d want=%0d", lat, WIDTH); end
    checks++; if (!bok) begin errors++; $display("FAIL mul_busy got=dropped want=high through done"); end
    checks++; if (bus.result !== exp) begin errors++; $display("FAIL mul_7x6 got=%h want=%h", bus.result, exp); end
    checks++; if (bus.alu_op !== 3'b000 || bus.alu_a !== '0 || bus.alu_b !== '0) begin
      errors++; $display("FAIL done_alu op=%b a=%h b=%h want all 0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    checks++; if (bus.result !== 32'd42) begin errors++; $display("FAIL result_hold got=%h want=0000002a", bus.result); end
  endtask

  task automatic test_mul_patterns();
    logic [1:0] tf[7]; logic [WIDTH-1:0] ta[7]; logic [WIDTH-1:0] tb_b[7]; logic [WIDTH-1:0] te[7];
    int lat; bit to; bit bok; logic [WIDTH-1:0] exp;
    tf[0] = 2'b00; ta[0] = 32'hFFFF_FFFF; tb_b[0] = 32'hFFFF_FFFF; te[0] = 32'h0000_0001;
    tf[1] = 2'b00; ta[1] = 32'h0001_0000; tb_b[1] = 32'h0001_0000; te[1] = 32'h0000_0000;
    tf[2] = 2'b01; ta[2] = 32'd3;         tb_b[2] = 32'd5;         te[2] = 32'd15;
    for (int i = 3; i < 7; i++) begin
      tf[i] = 2'(i & 1); ta[i] = $urandom; tb_b[i] = $urandom;
      te[i] = model(tf[i], ta[i], tb_b[i]);
    end
    for (int i = 0; i < 7; i++) begin
      send_op(tf[i], ta[i], tb_b[i], te[i]);
      accept();
      wait_done(lat, to, bok);
      exp = sb_q.pop_front();
      checks++; if (to || bus.result !== exp) begin
        errors++; $display("FAIL mul_%0d a=%h b=%h got=%h want=%h", i, ta[i], tb_b[i], bus.result, exp);
      end
    end
  endtask

  task automatic test_div();
    logic [1:0] tf[9]; logic [WIDTH-1:0] ta[9]; logic [WIDTH-1:0] tb_b[9]; logic [WIDTH-1:0] te[9];
    int lat; bit to; bit bok; logic [WIDTH-1:0] exp;
    tf[0] = 2'b10; ta[0] = 32'd100;       tb_b[0] = 32'd7;         te[0] = DIV_EN ? 32'd14 : 32'd0;
    tf[1] = 2'b11; ta[1] = 32'd100;       tb_b[1] = 32'd7;         te[1] = DIV_EN ? 32'd2 : 32'd0;
    tf[2] = 2'b10; ta[2] = 32'h8000_0000; tb_b[2] = 32'hFFFF_FFFF; te[2] = 32'd0;
    tf[3] = 2'b11; ta[3] = 32'h8000_0000; tb_b[3] = 32'hFFFF_FFFF; te[3] = DIV_EN ? 32'h8000_0000 : 32'd0;
    tf[4] = 2'b10; ta[4] = 32'd5;         tb_b[4] = 32'd0;         te[4] = DIV_EN ? 32'hFFFF_FFFF : 32'd0;
    tf[5] = 2'b11; ta[5] = 32'd5;         tb_b[5] = 32'd0;         te[5] = DIV_EN ? 32'd5 : 32'd0;
    for (int i = 6; i < 9; i++) begin
      tf[i] = 2'b10 | 2'(i & 1); ta[i] = $urandom; tb_b[i] = $urandom_range(1, 100000);
      te[i] = model(tf[i], ta[i], tb_b[i]);
    end
    for (int i = 0; i < 9; i++) begin
      send_op(tf[i], ta[i], tb_b[i], te[i]);
      accept();
      if (i == 0) begin
        checks++; if (bus.alu_op !== (DIV_EN ? 3'b001 : 3'b000) || bus.alu_b !== (DIV_EN ? tb_b[0] : '0)) begin
          errors++; $display("FAIL div_alu_drive op=%b b=%h want op=%b b=%h", bus.alu_op, bus.alu_b,
                             DIV_EN ? 3'b001 : 3'b000, DIV_EN ? tb_b[0] : 32'd0);
        end
      end
      wait_done(lat, to, bok);
      exp = sb_q.pop_front();
      checks++; if (to || bus.result !== exp) begin
        errors++; $display("FAIL div_%0d f=%b a=%h b=%h got=%h want=%h", i, tf[i], ta[i], tb_b[i], bus.result, exp);
      end
      if (i == 0) begin
        checks++; if (lat != WIDTH) begin errors++; $display("FAIL div_latency got=%0d want=%0d", lat, WIDTH); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat; bit to; bit bok; logic [WIDTH-1:0] exp;
    send_op(2'b00, 32'd3, 32'd4, 32'd12);
    accept();
    repeat (9) @(posedge clk);
    bus.src_a = 32'd9;
    bus.src_b = 32'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, to, bok);
    exp = sb_q.pop_front();
    checks++; if (to || lat != WIDTH - 10) begin errors++; $display("FAIL ignored_latency got=%0d want=%0d", lat, WIDTH - 10); end
    checks++; if (bus.result !== exp) begin errors++; $display("FAIL ignored_result got=%h want=%h", bus.result, exp); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL no_queueing busy=%b want=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; bit bok; logic [WIDTH-1:0] exp;
    send_op(2'b00, 32'd2, 32'd5, 32'd10);
    accept();
    wait_done(lat, to, bok);
    exp = sb_q.pop_front();
    checks++; if (to || bus.result !== exp) begin errors++; $display("FAIL b2b_first got=%h want=%h", bus.result, exp); end
    bus.src_a = 32'd3;
    bus.src_b = 32'd3;
    bus.start = 1'b1;
    sb_q.push_back(32'd9);
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_done_ignore busy=%b want=0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b want=1", bus.busy); end
    bus.start = 1'b0;
    wait_done(lat, to, bok);
    exp = sb_q.pop_front();
    checks++; if (to || lat != WIDTH || bus.result !== exp) begin
      errors++; $display("FAIL b2b_second lat=%0d got=%h want lat=%0d res=%h", lat, bus.result, WIDTH, exp);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; bit to; bit bok; bit seen; logic [WIDTH-1:0] exp;
    bus.func  = 2'b00;
    bus.src_a = 32'd5;
    bus.src_b = 32'd5;
    @(negedge clk);
    bus.start = 1'b1;
    accept();
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL async_rst_flags busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    checks++; if (bus.result !== '0) begin errors++; $display("FAIL async_rst_result got=%h want=0", bus.result); end
    checks++; if (bus.alu_op !== 3'b000 || bus.alu_a !== '0 || bus.alu_b !== '0) begin
      errors++; $display("FAIL async_rst_alu op=%b a=%h b=%h want all 0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done got=activity want=idle"); end
    send_op(2'b00, 32'd2, 32'd3, 32'd6);
    accept();
    wait_done(lat, to, bok);
    exp = sb_q.pop_front();
    checks++; if (to || bus.result !== exp) begin errors++; $display("FAIL post_reset_mul got=%h want=%h", bus.result, exp); end
  endtask

  initial begin
    test_reset();
    test_mul_latency();
    test_mul_patterns();
    test_div();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
